// File: rtl/trig_pipe_pkg.sv
// Shared constants and types for the SURF trigger pipe pulse shapers.
package trig_pipe_pkg;

  // Per-ring pulse widths in trigger-clock cycles
  localparam int unsigned PULSE_LEN_TOP    = 1;
  localparam int unsigned PULSE_LEN_MIDDLE = 3;
  localparam int unsigned PULSE_LEN_BOTTOM = 4;

  // Pulse down-counter width; covers PULSE_LEN up to 15
  localparam int unsigned CNT_W = 4;

  typedef logic [CNT_W-1:0] pulse_cnt_t;

  // Counter load value: the start edge is itself the first pulse cycle
  function automatic pulse_cnt_t pulse_load(input int unsigned len);
    return CNT_W'(len - 1);
  endfunction

endpackage : trig_pipe_pkg

// File: rtl/trigger_pulse_pn_if.sv
// Discriminator input / shaped trigger output bundle for one antenna ring.
interface trigger_pulse_pn_if;

  logic TRIG;        // asynchronous discriminator edge
  logic MASK;        // 1 = channel masked
  logic TRIG_P;      // posedge-aligned pulse
  logic TRIG_N;      // negedge-aligned pulse
  logic TRIG_P_DLY;  // TRIG_P one posedge later

  // Source side: discriminator/control drives, observes the pulses
  modport master (
    output TRIG,
    output MASK,
    input  TRIG_P,
    input  TRIG_N,
    input  TRIG_P_DLY
  );

  // Shaper side
  modport slave (
    input  TRIG,
    input  MASK,
    output TRIG_P,
    output TRIG_N,
    output TRIG_P_DLY
  );

endinterface : trigger_pulse_pn_if

// File: rtl/pn_pulse_side.sv
// One clock phase of the trigger shaper: edge detect, non-retriggerable
// down-counter and pulse output flop, all with synchronous clear.
// NEG_EDGE selects the falling clock edge as the active edge.
module pn_pulse_side
  import trig_pipe_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 1,
  parameter bit          NEG_EDGE  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  input  logic mask,
  output logic pulse
);

  localparam pulse_cnt_t LOAD_VAL = pulse_load(PULSE_LEN);

  logic       prev_d,  prev_q;
  pulse_cnt_t cnt_d,   cnt_q;
  logic       pulse_d, pulse_q;
  logic       rise_c;

  assign rise_c = trig & ~prev_q;

  // Next state: reset beats mask beats pulse end/start beats hold
  always_comb begin
    prev_d  = trig;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    if (rst) begin
      prev_d  = 1'b0;
      cnt_d   = '0;
      pulse_d = 1'b0;
    end else if (mask) begin
      // edge history keeps tracking so unmasking with TRIG high is silent
      cnt_d   = '0;
      pulse_d = 1'b0;
    end else if (pulse_q && (cnt_q != '0)) begin
      cnt_d   = cnt_q - pulse_cnt_t'(1);
    end else if (rise_c) begin
      // covers both idle start and back-to-back restart on the final cycle
      cnt_d   = LOAD_VAL;
      pulse_d = 1'b1;
    end else begin
      cnt_d   = '0;
      pulse_d = 1'b0;
    end
  end

  generate
    if (NEG_EDGE) begin : g_neg
      // State register on the falling edge
      always_ff @(negedge clk) begin
        prev_q  <= prev_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
      end
    end else begin : g_pos
      // State register on the rising edge
      always_ff @(posedge clk) begin
        prev_q  <= prev_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
      end
    end
  endgenerate

  assign pulse = pulse_q;

endmodule : pn_pulse_side

// File: rtl/trigger_pulse_pn.sv
// Trigger pulse shaper for one antenna ring: turns a discriminator edge into
// fixed-width pulses on the rising (P) and falling (N) clock phases, plus a
// one-cycle delayed P tap for scalers.
// Build option: define NEG_PATH_EN to include the falling-edge N chain;
// without it TRIG_N is tied low and no negedge logic exists.
module trigger_pulse_pn
  import trig_pipe_pkg::*;
#(
  parameter int unsigned PULSE_LEN = PULSE_LEN_TOP
) (
  input  logic               CLK,
  input  logic               RST,
  trigger_pulse_pn_if.slave  tp
);

  logic trig_p;
  logic trig_p_dly_d, trig_p_dly_q;

  // Rising-edge chain
  pn_pulse_side #(
    .PULSE_LEN (PULSE_LEN),
    .NEG_EDGE  (1'b0)
  ) u_p_side (
    .clk   (CLK),
    .rst   (RST),
    .trig  (tp.TRIG),
    .mask  (tp.MASK),
    .pulse (trig_p)
  );

`ifdef NEG_PATH_EN
  logic trig_n;

  // Falling-edge chain with its own edge history and counter
  pn_pulse_side #(
    .PULSE_LEN (PULSE_LEN),
    .NEG_EDGE  (1'b1)
  ) u_n_side (
    .clk   (CLK),
    .rst   (RST),
    .trig  (tp.TRIG),
    .mask  (tp.MASK),
    .pulse (trig_n)
  );

  assign tp.TRIG_N = trig_n;
`else
  assign tp.TRIG_N = 1'b0;
`endif

  // Delayed tap: follows TRIG_P, cleared only by reset (not by MASK)
  always_comb begin
    trig_p_dly_d = trig_p;
    if (RST) begin
      trig_p_dly_d = 1'b0;
    end
  end

  // Delayed tap register
  always_ff @(posedge CLK) begin
    trig_p_dly_q <= trig_p_dly_d;
  end

  assign tp.TRIG_P     = trig_p;
  assign tp.TRIG_P_DLY = trig_p_dly_q;

endmodule : trigger_pulse_pn

// File: tb/tb_trigger_pulse_pn.sv
// Directed bench for trigger_pulse_pn: three instances (PULSE_LEN 1, 3, 4)
// share clock and reset; each step pushes the expected pulse pattern and the
// outputs are popped and checked after the posedge (P, DLY) and negedge (N).
module tb_trigger_pulse_pn;
  import trig_pipe_pkg::*;

`ifdef NEG_PATH_EN
  localparam bit NEG = 1'b1;
`else
  localparam bit NEG = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] p;
    logic [2:0] n;
    logic [2:0] d;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  trigger_pulse_pn_if bus0 ();
  trigger_pulse_pn_if bus1 ();
  trigger_pulse_pn_if bus2 ();

  trigger_pulse_pn #(.PULSE_LEN(PULSE_LEN_TOP))    u_dut0 (.CLK(clk), .RST(rst), .tp(bus0));
  trigger_pulse_pn #(.PULSE_LEN(PULSE_LEN_MIDDLE)) u_dut1 (.CLK(clk), .RST(rst), .tp(bus1));
  trigger_pulse_pn #(.PULSE_LEN(PULSE_LEN_BOTTOM)) u_dut2 (.CLK(clk), .RST(rst), .tp(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int idx, input int s,
                       input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d step %0d: got %b expected %b", tag, idx, s, obs, exp);
    end
  endtask

  // Drive inputs for the coming posedge, then compare both phases
  task automatic drive_step(input string scen, input int s, input logic r,
                            input logic [2:0] t, input logic [2:0] m,
                            input exp_t e);
    exp_t cur;
    logic [2:0] obs_p, obs_n, obs_d;
    rst = r;
    bus0.TRIG = t[0]; bus0.MASK = m[0];
    bus1.TRIG = t[1]; bus1.MASK = m[1];
    bus2.TRIG = t[2]; bus2.MASK = m[2];
    sb_q.push_back(e);
    @(posedge clk);
    #2;
    cur   = sb_q.pop_front();
    obs_p = {bus2.TRIG_P, bus1.TRIG_P, bus0.TRIG_P};
    obs_d = {bus2.TRIG_P_DLY, bus1.TRIG_P_DLY, bus0.TRIG_P_DLY};
    for (int i = 0; i < 3; i++) begin
      check({scen, "_trig_p"}, i, s, obs_p[i], cur.p[i]);
      check({scen, "_trig_p_dly"}, i, s, obs_d[i], cur.d[i]);
    end
    @(negedge clk);
    #2;
    obs_n = {bus2.TRIG_N, bus1.TRIG_N, bus0.TRIG_N};
    for (int i = 0; i < 3; i++) begin
      check({scen, "_trig_n"}, i, s, obs_n[i], cur.n[i]);
    end
  endtask

  initial begin
    exp_t       e;
    logic [2:0] t;
    logic [2:0] m;

    // Reset held two cycles with TRIG toggling; everything stays low after
    for (int s = 0; s < 7; s++) begin
      t = (s < 2 && (s % 2 == 1)) ? 3'b111 : 3'b000;
      m = 3'b000;
      e = '0;
      drive_step("reset", s, (s < 2), t, m, e);
    end

    // PULSE_LEN=3, TRIG held 20 cycles: a single pulse
    for (int s = 0; s < 35; s++) begin
      t = 3'b000; m = 3'b000; e = '0;
      t[1]   = (s >= 10 && s <= 29);
      e.p[1] = (s >= 10 && s <= 12);
      e.n[1] = NEG & (s >= 10 && s <= 12);
      e.d[1] = (s >= 11 && s <= 13);
      drive_step("held", s, 1'b0, t, m, e);
    end

    // PULSE_LEN=4, rise inside pulse ignored, rise on last cycle restarts
    for (int s = 0; s < 23; s++) begin
      t = 3'b000; m = 3'b000; e = '0;
      t[2]   = (s == 10 || s == 12 || s == 14);
      e.p[2] = (s >= 10 && s <= 17);
      e.n[2] = NEG & (s >= 10 && s <= 17);
      e.d[2] = (s >= 11 && s <= 18);
      drive_step("retrig", s, 1'b0, t, m, e);
    end

    // PULSE_LEN=4, mask mid-pulse, then unmask with TRIG still high
    for (int s = 0; s < 31; s++) begin
      t = 3'b000; m = 3'b000; e = '0;
      t[2]   = (s >= 10 && s <= 25);
      m[2]   = (s >= 12 && s <= 19);
      e.p[2] = (s >= 10 && s <= 11);
      e.n[2] = NEG & (s >= 10 && s <= 11);
      e.d[2] = (s >= 11 && s <= 12);
      drive_step("mask", s, 1'b0, t, m, e);
    end

    // PULSE_LEN=1, held high then 1-high/1-low toggling
    for (int s = 0; s < 34; s++) begin
      t = 3'b000; m = 3'b000; e = '0;
      t[0]   = (s >= 2 && s <= 6) || (s >= 10 && s < 30 && (s % 2 == 0));
      e.p[0] = (s == 2) || (s >= 10 && s <= 28 && (s % 2 == 0));
      e.n[0] = NEG & e.p[0];
      e.d[0] = (s == 3) || (s >= 11 && s <= 29 && (s % 2 == 1));
      drive_step("toggle", s, 1'b0, t, m, e);
    end

    // PULSE_LEN=3, reset lands mid-pulse and clears the delayed tap too
    for (int s = 0; s < 13; s++) begin
      t = 3'b000; m = 3'b000; e = '0;
      t[1]   = (s >= 5 && s <= 6);
      e.p[1] = (s == 5);
      e.n[1] = NEG & (s == 5);
      drive_step("rst_mid", s, (s == 6), t, m, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_trigger_pulse_pn
